// File: rtl/race_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : race_key_conditioner
// Purpose  : Synchronises and debounces four active-low race buttons. Emits one
//            registered step pulse per press, or a chord pulse per player.
// Revision : 1.0  initial release
// ============================================================================
module race_key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       enable,
   input  logic [3:0] key_n,
   output logic       p1_left,
   output logic       p1_right,
   output logic       p2_left,
   output logic       p2_right,
   output logic       p1_chord,
   output logic       p2_chord,
   output logic [3:0] held
);

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_target = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] w_accept;

   // The input is inverted ahead of the synchroniser so that 1 always means pressed.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_sync1 <= 4'b0000;
         r_sync2 <= 4'b0000;
      end else begin
         r_sync1 <= ~key_n;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_key
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic [CNT_W-1:0] w_cnt_inc;
      logic             w_acc;

      assign w_cnt_inc = (r_cnt >= c_target) ? c_target : r_cnt + c_one;

      // The accept strobe is combinational, so the registered pulse lands on
      // the same edge on which the FSM enters HELD.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_acc       = 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_sync2[gi]) begin
                  if (c_target == c_one) begin
                     w_state_nxt = ST_HELD;
                     w_cnt_nxt   = '0;
                     w_acc       = 1'b1;
                  end else begin
                     w_state_nxt = ST_PRESS_WAIT;
                     w_cnt_nxt   = c_one;
                  end
               end
            end
            ST_PRESS_WAIT: begin
               if (!r_sync2[gi]) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else if (w_cnt_inc == c_target) begin
                  w_state_nxt = ST_HELD;
                  w_cnt_nxt   = '0;
                  w_acc       = 1'b1;
               end else begin
                  w_cnt_nxt   = w_cnt_inc;
               end
            end
            ST_HELD: begin
               if (!r_sync2[gi]) begin
                  if (c_target == c_one) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_state_nxt = ST_RELEASE_WAIT;
                     w_cnt_nxt   = c_one;
                  end
               end
            end
            ST_RELEASE_WAIT: begin
               if (r_sync2[gi]) begin
                  w_state_nxt = ST_HELD;
                  w_cnt_nxt   = '0;
               end else if (w_cnt_inc == c_target) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = w_cnt_inc;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
         end
      end

      assign w_accept[gi] = w_acc;
      assign held[gi]     = (r_state == ST_HELD) || (r_state == ST_RELEASE_WAIT);
   end

   // Same-cycle left+right accepts collapse into the chord pulse only.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         p1_left  <= 1'b0;
         p1_right <= 1'b0;
         p1_chord <= 1'b0;
         p2_left  <= 1'b0;
         p2_right <= 1'b0;
         p2_chord <= 1'b0;
      end else begin
         p1_left  <= enable &  w_accept[3] & ~w_accept[2];
         p1_right <= enable & ~w_accept[3] &  w_accept[2];
         p1_chord <= enable &  w_accept[3] &  w_accept[2];
         p2_left  <= enable &  w_accept[1] & ~w_accept[0];
         p2_right <= enable & ~w_accept[1] &  w_accept[0];
         p2_chord <= enable &  w_accept[1] &  w_accept[0];
      end
   end

endmodule
`default_nettype wire
